chip8_sprite_draw: RTL and testbench

Draw engine that sits upstream of the VGA scan-out stage and owns the write side of the 256-byte CHIP-8 framebuffer. It executes DXYN (XOR a sprite from main memory into the framebuffer, report collision) and 00E0 (clear screen) by read-modify-write through the framebuffer's second RAM port, while scan-out reads the other port. The framebuffer layout is byte address = row*8 + col/8, with bit 7 of each byte as the leftmost pixel.

---
 rtl/chip8_pkg.sv | 21 ++
 rtl/chip8_sprite_shifter.sv | 16 +
 rtl/chip8_sprite_draw.sv | 193 +++++++++++++++++++
 tb/tb_chip8_sprite_draw.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 framebuffer geometry and draw-engine state encoding.
// The scan-out stage imports the same geometry constants.
package chip8_pkg;

  localparam int FB_ROWS          = 32;
  localparam int FB_BYTES_PER_ROW = 8;
  localparam int FB_BYTES         = 256;
  localparam int FB_ADDR_W        = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_RDL,
    S_WRL,
    S_RDR,
    S_WRR,
    S_DONE
  } draw_state_t;

endpackage

// File: rtl/chip8_sprite_shifter.sv
// Splits one sprite byte across the two framebuffer bytes it can straddle
// for a given sub-byte x offset.
module chip8_sprite_shifter (
  input  logic [7:0] spr,
  input  logic [2:0] shift,
  output logic [7:0] left,
  output logic [7:0] right,
  output logic       need_right
);

  assign left       = spr >> shift;
  // A shift of 8 on an 8-bit value yields zero, so aligned sprites have no right part.
  assign right      = spr << (4'd8 - {1'b0, shift});
  assign need_right = (shift != 3'd0);

endmodule

// File: rtl/chip8_sprite_draw.sv
// CHIP-8 draw engine: executes DXYN (sprite XOR with collision) and 00E0
// (clear) by read-modify-write on framebuffer port B.
module chip8_sprite_draw #(
  parameter int FB_ROWS          = chip8_pkg::FB_ROWS,
  parameter int FB_BYTES_PER_ROW = chip8_pkg::FB_BYTES_PER_ROW
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        start,
  input  logic        clear,
  input  logic [7:0]  vx,
  input  logic [7:0]  vy,
  input  logic [3:0]  n,
  input  logic [11:0] i_reg,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  fb_addr,
  input  logic [7:0]  fb_rdata,
  output logic [7:0]  fb_wdata,
  output logic        fb_we,
  output logic        busy,
  output logic        done,
  output logic        collision
);

  import chip8_pkg::*;

  draw_state_t state_q, state_d;
  logic [5:0]  x0_q, x0_d;
  logic [4:0]  y0_q, y0_d;
  logic [3:0]  n_q, n_d;
  logic [11:0] i_q, i_d;
  logic [3:0]  r_q, r_d;
  logic [7:0]  left_q, left_d;
  logic [7:0]  right_q, right_d;
  logic        need_right_q, need_right_d;
  logic        collision_q, collision_d;
  logic [7:0]  fb_addr_q, fb_addr_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic        fb_we_q, fb_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  sh_left, sh_right;
  logic        sh_need_right;
  logic [5:0]  row_sum;
  logic [7:0]  row_addr;

  // Coordinates are taken modulo the screen size, so the upper register bits are dropped.
  wire unused_coord_bits = ^{vx[7:6], vy[7:5]};

  chip8_sprite_shifter u_shifter (
    .spr        (mem_rdata),
    .shift      (x0_q[2:0]),
    .left       (sh_left),
    .right      (sh_right),
    .need_right (sh_need_right)
  );

  assign row_sum  = {1'b0, y0_q} + {2'b00, r_q};
  assign row_addr = FB_ADDR_W'(int'(row_sum[4:0]) * FB_BYTES_PER_ROW + int'(x0_q[5:3]));

  always_comb begin
    // NOTE: every _d gets a hold value first so no path through the case infers a latch.
    state_d      = state_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    n_d          = n_q;
    i_d          = i_q;
    r_d          = r_q;
    left_d       = left_q;
    right_d      = right_q;
    need_right_d = need_right_q;
    collision_d  = collision_q;
    fb_addr_d    = fb_addr_q;
    mem_addr_d   = mem_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (clear || start) begin
          x0_d        = vx[5:0];
          y0_d        = vy[4:0];
          n_d         = n;
          i_d         = i_reg;
          r_d         = 4'd0;
          collision_d = 1'b0;
          if (clear) begin
            state_d   = S_CLR;
            fb_addr_d = '0;
          end else begin
            state_d   = S_FETCH;
          end
        end
      end
      S_CLR: begin
        fb_addr_d = fb_addr_q + 8'd1;
        if (fb_addr_q == 8'(FB_BYTES - 1)) state_d = S_DONE;
      end
      S_FETCH: begin
        // Bottom clipping: rows past the last screen row are dropped, not wrapped.
        if (r_q == n_q || int'(row_sum) >= FB_ROWS) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_RDL;
          fb_addr_d = row_addr;
        end
      end
      S_RDL: begin
        left_d       = sh_left;
        right_d      = sh_right;
        need_right_d = sh_need_right;
        state_d      = S_WRL;
      end
      S_WRL: begin
        collision_d = collision_q | (|(fb_rdata & left_q));
        if (!need_right_q || x0_q[5:3] == 3'd7) begin
          r_d     = r_q + 4'd1;
          state_d = S_FETCH;
        end else begin
          fb_addr_d = fb_addr_q + 8'd1;
          state_d   = S_RDR;
        end
      end
      S_RDR: state_d = S_WRR;
      S_WRR: begin
        collision_d = collision_q | (|(fb_rdata & right_q));
        r_d         = r_q + 4'd1;
        state_d     = S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Memory address is presented for the whole FETCH cycle so data lands in RDL.
    if (state_d == S_FETCH) mem_addr_d = i_d + {8'd0, r_d};

    fb_we_d = (state_d == S_CLR) || (state_d == S_WRL) || (state_d == S_WRR);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      n_q          <= '0;
      i_q          <= '0;
      r_q          <= '0;
      left_q       <= '0;
      right_q      <= '0;
      need_right_q <= 1'b0;
      collision_q  <= 1'b0;
      fb_addr_q    <= '0;
      mem_addr_q   <= '0;
      fb_we_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q      <= state_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      n_q          <= n_d;
      i_q          <= i_d;
      r_q          <= r_d;
      left_q       <= left_d;
      right_q      <= right_d;
      need_right_q <= need_right_d;
      collision_q  <= collision_d;
      fb_addr_q    <= fb_addr_d;
      mem_addr_q   <= mem_addr_d;
      fb_we_q      <= fb_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Write data must follow the RAM read in the same cycle, so it is the only unregistered output.
  always_comb begin
    fb_wdata = 8'h00;
    if (state_q == S_WRL) fb_wdata = fb_rdata ^ left_q;
    else if (state_q == S_WRR) fb_wdata = fb_rdata ^ right_q;
  end

  assign fb_addr   = fb_addr_q;
  assign mem_addr  = mem_addr_q;
  assign fb_we     = fb_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Self-checking bench for chip8_sprite_draw: RAM models on both sides and a
// per-pixel reference model of DXYN / 00E0.
module tb_chip8_sprite_draw;

  logic        clk50 = 1'b0;
  logic        reset, start, clear;
  logic [7:0]  vx, vy;
  logic [3:0]  n;
  logic [11:0] i_reg;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata, fb_addr, fb_rdata, fb_wdata;
  logic        fb_we, busy, done, collision;

  logic [7:0]  mem [4096];
  logic [7:0]  fb [256];
  logic [7:0]  exp_fb [256];
  logic [7:0]  wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  int          done_count = 0;
  int          passed = 0;
  int          total = 0;

  always #10 clk50 = ~clk50;

  chip8_sprite_draw dut (
    .clk50     (clk50),
    .reset     (reset),
    .start     (start),
    .clear     (clear),
    .vx        (vx),
    .vy        (vy),
    .n         (n),
    .i_reg     (i_reg),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .fb_addr   (fb_addr),
    .fb_rdata  (fb_rdata),
    .fb_wdata  (fb_wdata),
    .fb_we     (fb_we),
    .busy      (busy),
    .done      (done),
    .collision (collision)
  );

  // Synchronous RAMs with one cycle of read latency; fb port B reads the old value.
  always @(posedge clk50) begin
    mem_rdata <= mem[mem_addr];
    fb_rdata  <= fb[fb_addr];
    if (fb_we) begin
      fb[fb_addr] = fb_wdata;
      wr_addr_q.push_back(fb_addr);
      wr_data_q.push_back(fb_wdata);
    end
  end

  always @(negedge clk50) if (done) done_count++;

  // Reference DXYN on exp_fb, pixel by pixel.
  function automatic void model_draw(input int x, input int y, input int nn, input int ii,
                                     output bit coll, output int rows);
    coll = 1'b0;
    rows = 0;
    for (int r = 0; r < nn; r++) begin
      int row;
      logic [7:0] b;
      row = (y % 32) + r;
      if (row >= 32) break;
      rows++;
      b = mem[(ii + r) % 4096];
      for (int p = 0; p < 8; p++) begin
        if (b[7-p]) begin
          int col, addr;
          logic [7:0] m;
          col = (x % 64) + p;
          if (col < 64) begin
            addr = row * 8 + col / 8;
            m = 8'h80 >> (col % 8);
            if ((exp_fb[addr] & m) != 0) coll = 1'b1;
            exp_fb[addr] ^= m;
          end
        end
      end
    end
  endfunction

  function automatic int fb_diffs(output int first);
    int d = 0;
    first = -1;
    for (int a = 0; a < 256; a++) begin
      if (fb[a] !== exp_fb[a]) begin
        if (first < 0) first = a;
        d++;
      end
    end
    return d;
  endfunction

  task automatic preload_fb(input int mode);
    for (int a = 0; a < 256; a++) begin
      fb[a] = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : (mode == 2) ? 8'hAA : 8'($urandom);
      exp_fb[a] = fb[a];
    end
  endtask

  task automatic run_draw(input int x, input int y, input int nn, input int ii, input string tag);
    bit exp_coll;
    int rows, cost, exp_cyc, exp_wr, cyc, d, first;
    model_draw(x, y, nn, ii, exp_coll, rows);
    cost    = ((x % 8) == 0 || (x % 64) >= 56) ? 3 : 5;
    exp_cyc = rows * cost + 2;
    exp_wr  = rows * ((cost == 3) ? 1 : 2);
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk50);
    vx = 8'(x); vy = 8'(y); n = 4'(nn); i_reg = 12'(ii); start = 1'b1;
    @(negedge clk50);
    start = 1'b0;
    cyc = 1;
    total++;
    if (busy !== 1'b1) $display("FAIL %s_busy: got %b want 1", tag, busy);
    else passed++;
    while (done !== 1'b1 && cyc < 400) begin
      @(negedge clk50);
      cyc++;
    end
    total++;
    if (done !== 1'b1) $display("FAIL %s_timeout: done never rose in %0d cycles", tag, cyc);
    else passed++;
    total++;
    if (cyc != exp_cyc) $display("FAIL %s_latency: got %0d want %0d", tag, cyc, exp_cyc);
    else passed++;
    total++;
    if (collision !== exp_coll) $display("FAIL %s_collision: got %b want %b", tag, collision, exp_coll);
    else passed++;
    @(negedge clk50);
    total++;
    if (wr_addr_q.size() != exp_wr) $display("FAIL %s_writes: got %0d want %0d", tag, wr_addr_q.size(), exp_wr);
    else passed++;
    d = fb_diffs(first);
    total++;
    if (d != 0) $display("FAIL %s_fb: %0d bytes differ, fb[%0d] got %h want %h", tag, d, first, fb[first], exp_fb[first]);
    else passed++;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL %s_idle: got busy=%b done=%b want 0 0", tag, busy, done);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; clear = 1'b0; vx = '0; vy = '0; n = '0; i_reg = '0;
    repeat (3) @(negedge clk50);
    total++;
    if ({busy, done, fb_we, collision} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {busy, done, fb_we, collision});
    else passed++;
    total++;
    if (fb_addr !== 8'h00 || fb_wdata !== 8'h00 || mem_addr !== 12'h000)
      $display("FAIL reset_addr: got fb_addr=%h fb_wdata=%h mem_addr=%h want 0", fb_addr, fb_wdata, mem_addr);
    else passed++;
    reset = 1'b0;
    @(negedge clk50);
  endtask

  task automatic test_clear();
    int cyc, bad;
    preload_fb(1);
    for (int a = 0; a < 256; a++) exp_fb[a] = 8'h00;
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk50);
    clear = 1'b1;
    @(negedge clk50);
    clear = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 400) begin
      @(negedge clk50);
      cyc++;
    end
    // 256 CLR cycles then the DONE cycle, counting from the first cycle after the accept edge.
    total++;
    if (cyc != 257) $display("FAIL clear_latency: got %0d want 257", cyc);
    else passed++;
    total++;
    if (collision !== 1'b0) $display("FAIL clear_collision: got %b want 0", collision);
    else passed++;
    bad = (wr_addr_q.size() == 256) ? 0 : 1;
    for (int k = 0; k < wr_addr_q.size() && k < 256; k++)
      if (wr_addr_q[k] != 8'(k) || wr_data_q[k] != 8'h00) bad++;
    total++;
    if (bad != 0) $display("FAIL clear_writes: got %0d writes with %0d bad want 256 sequential zeros", wr_addr_q.size(), bad);
    else passed++;
    @(negedge clk50);
  endtask

  task automatic test_aligned();
    preload_fb(0);
    mem[12'h200] = 8'hF0;
    run_draw(8, 0, 1, 12'h200, "aligned1");
    total++;
    if (fb[1] !== 8'hF0 || collision !== 1'b0) $display("FAIL aligned_fb1: got %h coll=%b want f0 0", fb[1], collision);
    else passed++;
    run_draw(8, 0, 1, 12'h200, "aligned2");
    total++;
    if (fb[1] !== 8'h00 || collision !== 1'b1) $display("FAIL aligned_erase: got %h coll=%b want 00 1", fb[1], collision);
    else passed++;
  endtask

  task automatic test_unaligned();
    preload_fb(0);
    mem[12'h210] = 8'hFF;
    run_draw(4, 2, 1, 12'h210, "unaligned");
    total++;
    if (fb[16] !== 8'h0F || fb[17] !== 8'hF0) $display("FAIL unaligned_bytes: got %h %h want 0f f0", fb[16], fb[17]);
    else passed++;
  endtask

  task automatic test_clipping();
    for (int k = 0; k < 4; k++) mem[12'h220 + k] = 8'hFF;
    preload_fb(0);
    run_draw(60, 30, 4, 12'h220, "clip");
    total++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] != 8'd247 || wr_addr_q[1] != 8'd255 || fb[247] !== 8'h0F || fb[255] !== 8'h0F)
      $display("FAIL clip_targets: got %0d writes fb247=%h fb255=%h want 2 writes 0f 0f", wr_addr_q.size(), fb[247], fb[255]);
    else passed++;
    preload_fb(0);
    run_draw(68, 2, 1, 12'h220, "wrap");
    total++;
    if (fb[16] !== 8'h0F || fb[17] !== 8'hF0) $display("FAIL wrap_bytes: got %h %h want 0f f0", fb[16], fb[17]);
    else passed++;
    preload_fb(3);
    run_draw(21, 9, 0, 12'h220, "n_zero");
  endtask

  task automatic test_random();
    for (int t = 0; t < 16; t++) begin
      preload_fb((t % 3 == 0) ? 0 : 3);
      run_draw(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(15)),
               int'($urandom_range(4095)), "random");
    end
  endtask

  task automatic test_mid_reset();
    int d, first, dc;
    preload_fb(0);
    for (int k = 0; k < 5; k++) mem[12'h300 + k] = 8'($urandom_range(255, 1));
    @(negedge clk50);
    vx = 8'd13; vy = 8'd5; n = 4'd5; i_reg = 12'h300; start = 1'b1;
    @(negedge clk50);
    start = 1'b0;
    // Cycles 1..5 are FETCH, RDL, WRL, RDR, WRR of row 0.
    repeat (4) @(negedge clk50);
    total++;
    if (fb_we !== 1'b1) $display("FAIL midreset_wrr_we: got %b want 1", fb_we);
    else passed++;
    dc = done_count;
    #2 reset = 1'b1;
    #1;
    total++;
    if (fb_we !== 1'b0 || busy !== 1'b0) $display("FAIL midreset_async: got fb_we=%b busy=%b want 0 0", fb_we, busy);
    else passed++;
    repeat (2) @(negedge clk50);
    reset = 1'b0;
    repeat (2) @(negedge clk50);
    total++;
    if (done_count != dc) $display("FAIL midreset_nodone: got %0d done pulses want 0", done_count - dc);
    else passed++;
    // Only row 0's left byte was written before the abort.
    exp_fb[5 * 8 + 1] ^= mem[12'h300] >> 5;
    d = fb_diffs(first);
    total++;
    if (d != 0) $display("FAIL midreset_partial: %0d bytes differ, fb[%0d] got %h want %h", d, first, fb[first], exp_fb[first]);
    else passed++;
    run_draw(13, 5, 5, 12'h300, "after_reset");
  endtask

  task automatic test_priority();
    int dc, cyc, bad;
    preload_fb(2);
    for (int a = 0; a < 256; a++) exp_fb[a] = 8'h00;
    mem[12'h240] = 8'hFF;
    wr_addr_q.delete();
    wr_data_q.delete();
    dc = done_count;
    @(negedge clk50);
    vx = 8'd0; vy = 8'd0; n = 4'd1; i_reg = 12'h240; start = 1'b1; clear = 1'b1;
    @(negedge clk50);
    start = 1'b0; clear = 1'b0;
    repeat (10) @(negedge clk50);
    start = 1'b1;
    @(negedge clk50);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 400) begin
      @(negedge clk50);
      cyc++;
    end
    repeat (10) @(negedge clk50);
    total++;
    if (done_count - dc != 1) $display("FAIL prio_done_pulses: got %0d want 1", done_count - dc);
    else passed++;
    bad = (wr_addr_q.size() == 256) ? 0 : 1;
    for (int k = 0; k < wr_addr_q.size() && k < 256; k++)
      if (wr_addr_q[k] != 8'(k) || wr_data_q[k] != 8'h00) bad++;
    total++;
    if (bad != 0 || collision !== 1'b0)
      $display("FAIL prio_clear_only: got %0d writes %0d bad coll=%b want 256 zeros coll 0", wr_addr_q.size(), bad, collision);
    else passed++;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    preload_fb(0);
    test_reset();
    test_clear();
    test_aligned();
    test_unaligned();
    test_clipping();
    test_random();
    test_mid_reset();
    test_priority();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
